// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and parameter defaults.
package pwm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } pwm_state_e;

    // Matches the tone generator's low_count width.
    localparam int unsigned CntWDefault       = 10;
    localparam int unsigned SyncStagesDefault = 2;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous PWM input and flags rising/falling edges of the
// synchronized level.
module pwm_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high and low phase lengths of a PWM tone in clk cycles and reports each
// complete period; flags silence when a phase runs past the counter range.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = CntWDefault,
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] low_count,
    output logic             period_valid,
    output logic             silent
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic s, rise, fall;

    pwm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] high_count_q, high_count_d;
    logic [CNT_W-1:0] low_count_q, low_count_d;
    logic             period_valid_q, period_valid_d;
    logic             silent_q, silent_d;

    always_comb begin
        state_d        = state_q;
        hcnt_d         = hcnt_q;
        lcnt_d         = lcnt_q;
        high_count_d   = high_count_q;
        low_count_d    = low_count_q;
        period_valid_d = 1'b0;
        silent_d       = silent_q;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StHigh;
                    hcnt_d  = CntOne;
                    lcnt_d  = '0;
                end
            end
            StHigh: begin
                if (fall) begin
                    state_d = StLow;
                    lcnt_d  = CntOne;
                end else if (s) begin
                    // A saturated counter with no edge means the tone has stopped.
                    if (hcnt_q == CntMax) begin
                        state_d  = StIdle;
                        hcnt_d   = '0;
                        lcnt_d   = '0;
                        silent_d = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + CntOne;
                    end
                end
            end
            StLow: begin
                if (rise) begin
                    high_count_d   = hcnt_q;
                    low_count_d    = lcnt_q;
                    period_valid_d = 1'b1;
                    silent_d       = 1'b0;
                    hcnt_d         = CntOne;
                    lcnt_d         = '0;
                    state_d        = StHigh;
                end else if (!s) begin
                    if (lcnt_q == CntMax) begin
                        state_d  = StIdle;
                        hcnt_d   = '0;
                        lcnt_d   = '0;
                        silent_d = 1'b1;
                    end else begin
                        lcnt_d = lcnt_q + CntOne;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                hcnt_d  = '0;
                lcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            hcnt_q         <= '0;
            lcnt_q         <= '0;
            high_count_q   <= '0;
            low_count_q    <= '0;
            period_valid_q <= 1'b0;
            silent_q       <= 1'b1;
        end else begin
            state_q        <= state_d;
            hcnt_q         <= hcnt_d;
            lcnt_q         <= lcnt_d;
            high_count_q   <= high_count_d;
            low_count_q    <= low_count_d;
            period_valid_q <= period_valid_d;
            silent_q       <= silent_d;
        end
    end

    assign high_count   = high_count_q;
    assign low_count    = low_count_q;
    assign period_valid = period_valid_q;
    assign silent       = silent_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: three instances (default, CNT_W=4, SYNC_STAGES=3)
// with a per-instance scoreboard of expected reports and their due cycles.
module tb_pwm_capture;

    logic       clk;
    logic       rst;
    logic [2:0] pwm;
    logic [9:0] hc_a, lc_a, hc_c, lc_c;
    logic [3:0] hc_b, lc_b;
    logic [2:0] pv, sil;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int npulse [3] = '{0, 0, 0};

    typedef struct {
        int hc;
        int lc;
        int due;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_capture u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm[0]),
        .high_count   (hc_a),
        .low_count    (lc_a),
        .period_valid (pv[0]),
        .silent       (sil[0])
    );

    pwm_capture #(
        .CNT_W       (4),
        .SYNC_STAGES (2)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm[1]),
        .high_count   (hc_b),
        .low_count    (lc_b),
        .period_valid (pv[1]),
        .silent       (sil[1])
    );

    pwm_capture #(
        .CNT_W       (10),
        .SYNC_STAGES (3)
    ) u_dut_c (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm[2]),
        .high_count   (hc_c),
        .low_count    (lc_c),
        .period_valid (pv[2]),
        .silent       (sil[2])
    );

    function automatic logic [31:0] hc_of(input int i);
        logic [31:0] r;
        r = '0;
        case (i)
            0: r = 32'(hc_a);
            1: r = 32'(hc_b);
            default: r = 32'(hc_c);
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lc_of(input int i);
        logic [31:0] r;
        r = '0;
        case (i)
            0: r = 32'(lc_a);
            1: r = 32'(lc_b);
            default: r = 32'(lc_c);
        endcase
        return r;
    endfunction

    function automatic int sync_of(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a rise on instance d; when it closes a period, the expected report is queued.
    task automatic do_rise(input int d, input bit rep, input int h, input int l);
        exp_t e;
        pwm[d] = 1'b1;
        if (rep) begin
            e.hc  = h;
            e.lc  = l;
            e.due = cyc + sync_of(d) + 1;
            case (d)
                0: sb0.push_back(e);
                1: sb1.push_back(e);
                default: sb2.push_back(e);
            endcase
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_hc[%0d]", tag, i), hc_of(i), 32'd0);
            check($sformatf("%s_lc[%0d]", tag, i), lc_of(i), 32'd0);
            check($sformatf("%s_pv[%0d]", tag, i), 32'(pv[i]), 32'd0);
            check($sformatf("%s_silent[%0d]", tag, i), 32'(sil[i]), 32'd1);
        end
    endtask

    // Scoreboard monitor: every period_valid pulse must match the oldest queued report.
    initial begin : mon
        exp_t e;
        logic empty;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (pv[i] === 1'b1) begin
                    npulse[i]++;
                    empty = 1'b0;
                    e = '{0, 0, 0};
                    case (i)
                        0: if (sb0.size() == 0) empty = 1'b1; else e = sb0.pop_front();
                        1: if (sb1.size() == 0) empty = 1'b1; else e = sb1.pop_front();
                        default: if (sb2.size() == 0) empty = 1'b1; else e = sb2.pop_front();
                    endcase
                    check($sformatf("pv_expected[%0d]", i), 32'(empty), 32'd0);
                    if (!empty) begin
                        check($sformatf("pv_hc[%0d]", i), hc_of(i), 32'(e.hc));
                        check($sformatf("pv_lc[%0d]", i), lc_of(i), 32'(e.lc));
                        check($sformatf("pv_cycle[%0d]", i), 32'(cyc), 32'(e.due));
                        check($sformatf("pv_silent[%0d]", i), 32'(sil[i]), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        pwm = 3'b000;
        hold(3);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle input: no reports, still silent.
        hold(50);
        check_reset_outputs("idle50");
        check("idle_pulses", 32'(npulse[0]), 32'd0);

        // 4 high / 6 low, five periods plus a closing rise.
        for (int p = 0; p < 5; p++) begin
            do_rise(0, p > 0, 4, 6);
            hold(4);
            pwm[0] = 1'b0;
            hold(6);
        end
        do_rise(0, 1'b1, 4, 6);
        hold(5);
        check("sq46_pulses", 32'(npulse[0]), 32'd5);
        check("sq46_silent", 32'(sil[0]), 32'd0);
        check("sq46_hc_hold", hc_of(0), 32'd4);
        check("sq46_lc_hold", lc_of(0), 32'd6);

        // Asynchronous reset in the middle of a low phase.
        pwm[0] = 1'b0;
        hold(3);
        #1 rst = 1'b1;
        #1;
        check("async_rst_hc", hc_of(0), 32'd0);
        check("async_rst_lc", lc_of(0), 32'd0);
        check("async_rst_pv", 32'(pv[0]), 32'd0);
        check("async_rst_silent", 32'(sil[0]), 32'd1);
        @(negedge clk);
        hold(2);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        for (int p = 0; p < 3; p++) begin
            do_rise(0, p > 0, 5, 5);
            hold(5);
            pwm[0] = 1'b0;
            hold(5);
        end
        do_rise(0, 1'b1, 5, 5);
        hold(5);
        pwm[0] = 1'b0;
        check("sq55_pulses", 32'(npulse[0]), 32'd8);
        check("sq55_hc", hc_of(0), 32'd5);
        check("sq55_lc", lc_of(0), 32'd5);

        // CNT_W=4: closing rise exactly at lcnt saturation, then a stuck-high timeout.
        do_rise(1, 1'b0, 0, 0);
        hold(3);
        pwm[1] = 1'b0;
        hold(15);
        do_rise(1, 1'b1, 3, 15);
        hold(4);
        check("sat_edge_pulses", 32'(npulse[1]), 32'd1);
        check("sat_edge_silent", 32'(sil[1]), 32'd0);
        hold(30);
        check("timeout_silent", 32'(sil[1]), 32'd1);
        check("timeout_pulses", 32'(npulse[1]), 32'd1);
        check("timeout_hc_hold", hc_of(1), 32'd3);
        check("timeout_lc_hold", lc_of(1), 32'd15);

        // After a timeout the first rise only arms the measurement.
        pwm[1] = 1'b0;
        hold(3);
        do_rise(1, 1'b0, 0, 0);
        hold(3);
        pwm[1] = 1'b0;
        hold(3);
        check("rearm_no_pulse", 32'(npulse[1]), 32'd1);
        do_rise(1, 1'b1, 3, 3);
        hold(5);
        pwm[1] = 1'b0;
        check("rearm_pulses", 32'(npulse[1]), 32'd2);
        check("rearm_silent", 32'(sil[1]), 32'd0);

        // SYNC_STAGES=3 latency.
        do_rise(2, 1'b0, 0, 0);
        hold(4);
        pwm[2] = 1'b0;
        hold(4);
        do_rise(2, 1'b1, 4, 4);
        hold(7);
        pwm[2] = 1'b0;
        check("sync3_pulses", 32'(npulse[2]), 32'd1);

        hold(2);
        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        check("sb2_drained", 32'(sb2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
